// File: rtl/pe_array_os_ctrl_pkg.sv
// Shared types and width helpers for the output-stationary PE array.
package pe_array_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned prod_width(input int unsigned in_width);
    return 2 * in_width;
  endfunction

  function automatic int unsigned row_idx_width(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/pe_array_os_ctrl_if.sv
// Operand, control and result-drain signals of the PE array, grouped as one bus.
interface pe_array_os_ctrl_if
  import pe_array_pkg::*;
#(
  parameter int unsigned NumRows      = 4,
  parameter int unsigned NumCols      = 4,
  parameter int unsigned InDataWidth  = 8,
  parameter int unsigned OutDataWidth = 32,
  parameter int unsigned KCntWidth    = 16
);
  localparam int unsigned RowW = row_idx_width(NumRows);

  logic                           start_i;
  logic [KCntWidth-1:0]           k_len_i;
  logic                           busy_o;
  logic signed [InDataWidth-1:0]  a_i [NumRows];
  logic signed [InDataWidth-1:0]  b_i [NumCols];
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic signed [OutDataWidth-1:0] c_o [NumCols];
  logic [RowW-1:0]                c_row_o;
  logic                           c_valid_o;
  logic                           c_ready_i;
  logic                           done_o;

  modport master (
    output start_i, k_len_i, a_i, b_i, in_valid_i, c_ready_i,
    input  busy_o, in_ready_o, c_o, c_row_o, c_valid_o, done_o
  );

  modport slave (
    input  start_i, k_len_i, a_i, b_i, in_valid_i, c_ready_i,
    output busy_o, in_ready_o, c_o, c_row_o, c_valid_o, done_o
  );

endinterface

// File: rtl/pe_array_os_ctrl_mac_pe_acc.sv
// One signed multiply-accumulate cell; accumulation wraps modulo 2^OutDataWidth.
module mac_pe_acc
  import pe_array_pkg::*;
#(
  parameter int unsigned InDataWidth  = 8,
  parameter int unsigned OutDataWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic signed [InDataWidth-1:0]  a_i,
  input  logic signed [InDataWidth-1:0]  b_i,
  output logic signed [OutDataWidth-1:0] acc_o
);
  localparam int unsigned ProdW = prod_width(InDataWidth);

  logic signed [ProdW-1:0] prod;

  assign prod = ProdW'(a_i) * ProdW'(b_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      acc_o <= '0;
    end else if (en_i) begin
      acc_o <= acc_o + OutDataWidth'(prod);
    end
  end

endmodule

// File: rtl/pe_array_os_ctrl.sv
// Output-stationary NumRows x NumCols MAC array with K-loop sequencer and row-by-row drain.
module pe_array_os_ctrl
  import pe_array_pkg::*;
#(
  parameter int unsigned NumRows      = 4,
  parameter int unsigned NumCols      = 4,
  parameter int unsigned InDataWidth  = 8,
  parameter int unsigned OutDataWidth = 32,
  parameter int unsigned KCntWidth    = 16
) (
  input logic              clk_i,
  input logic              rst_i,
  pe_array_os_ctrl_if.slave bus
);
  localparam int unsigned     RowW    = row_idx_width(NumRows);
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  state_e                         state;
  logic [KCntWidth-1:0]           k_len;
  logic [KCntWidth-1:0]           beat_cnt;
  logic [RowW-1:0]                row_cnt;
  logic                           busy_q;
  logic                           in_ready_q;
  logic                           c_valid_q;
  logic                           done_q;
  logic                           beat;
  logic                           clr;
  logic signed [OutDataWidth-1:0] acc   [NumRows][NumCols];
  logic signed [OutDataWidth-1:0] c_mux [NumCols];

  assign beat = in_ready_q & bus.in_valid_i;
  assign clr  = (state == IDLE) & bus.start_i;

  for (genvar m = 0; m < NumRows; m++) begin : g_row
    for (genvar n = 0; n < NumCols; n++) begin : g_col
      mac_pe_acc #(
        .InDataWidth (InDataWidth),
        .OutDataWidth(OutDataWidth)
      ) u_pe (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .clr_i(clr),
        .en_i (beat),
        .a_i  (bus.a_i[m]),
        .b_i  (bus.b_i[n]),
        .acc_o(acc[m][n])
      );
    end
  end

  // Comparing against k_len-1 (k_len nonzero in ACC) keeps the full counter range usable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      k_len      <= '0;
      beat_cnt   <= '0;
      row_cnt    <= '0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      c_valid_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            k_len    <= bus.k_len_i;
            beat_cnt <= '0;
            row_cnt  <= '0;
            busy_q   <= 1'b1;
            if (bus.k_len_i == '0) begin
              state     <= DRAIN;
              c_valid_q <= 1'b1;
            end else begin
              state      <= ACC;
              in_ready_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (beat) begin
            if (beat_cnt == k_len - KCntWidth'(1)) begin
              state      <= DRAIN;
              beat_cnt   <= '0;
              in_ready_q <= 1'b0;
              c_valid_q  <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + KCntWidth'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.c_ready_i) begin
            if (row_cnt == LastRow) begin
              state     <= DONE;
              row_cnt   <= '0;
              c_valid_q <= 1'b0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              row_cnt <= row_cnt + RowW'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Row mux reads only registered accumulators and is forced to zero outside DRAIN.
  always_comb begin
    for (int unsigned n = 0; n < NumCols; n++) begin
      c_mux[n] = '0;
      if (c_valid_q) begin
        c_mux[n] = acc[row_cnt][n];
      end
    end
  end

  assign bus.c_o        = c_mux;
  assign bus.c_row_o    = row_cnt;
  assign bus.c_valid_o  = c_valid_q;
  assign bus.busy_o     = busy_q;
  assign bus.in_ready_o = in_ready_q;
  assign bus.done_o     = done_q;

endmodule

// File: tb/tb_pe_array_os_ctrl.sv
// Directed bench for pe_array_os_ctrl: 32-bit and 16-bit accumulator instances share stimulus.
module tb_pe_array_os_ctrl;

  logic clk;
  logic rst;
  logic start;
  logic [15:0] k_len;
  logic signed [7:0] a [4];
  logic signed [7:0] b [4];
  logic in_valid;
  logic c_ready;

  int n_checks;
  int n_fail;

  logic signed [63:0] exp_c  [4][4];
  logic signed [63:0] exp_16 [4][4];

  pe_array_os_ctrl_if #(.OutDataWidth(32)) bus ();
  pe_array_os_ctrl_if #(.OutDataWidth(16)) bus16 ();

  assign bus.start_i      = start;
  assign bus.k_len_i      = k_len;
  assign bus.a_i          = a;
  assign bus.b_i          = b;
  assign bus.in_valid_i   = in_valid;
  assign bus.c_ready_i    = c_ready;
  assign bus16.start_i    = start;
  assign bus16.k_len_i    = k_len;
  assign bus16.a_i        = a;
  assign bus16.b_i        = b;
  assign bus16.in_valid_i = in_valid;
  assign bus16.c_ready_i  = c_ready;

  pe_array_os_ctrl #(
    .NumRows(4), .NumCols(4), .InDataWidth(8), .OutDataWidth(32), .KCntWidth(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  pe_array_os_ctrl #(
    .NumRows(4), .NumCols(4), .InDataWidth(8), .OutDataWidth(16), .KCntWidth(16)
  ) dut16 (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus16.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " busy"},     bus.busy_o,     0);
    chk({tag, " in_ready"}, bus.in_ready_o, 0);
    chk({tag, " c_valid"},  bus.c_valid_o,  0);
    chk({tag, " done"},     bus.done_o,     0);
    chk({tag, " c_row"},    bus.c_row_o,    0);
    chk({tag, " busy16"},   bus16.busy_o,   0);
    chk({tag, " valid16"},  bus16.c_valid_o, 0);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("%s c_o[%0d]", tag, n), bus.c_o[n], 0);
      chk($sformatf("%s c16[%0d]", tag, n), bus16.c_o[n], 0);
    end
  endtask

  task automatic start_tile(input int k);
    k_len = 16'(k);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start busy", bus.busy_o, 1);
    chk("start in_ready", bus.in_ready_o, (k == 0) ? 0 : 1);
    chk("start c_valid", bus.c_valid_o, (k == 0) ? 1 : 0);
  endtask

  task automatic feed(input int k, input bit gaps);
    int sent = 0;
    int cnt  = 0;
    bit take;
    while (sent < k && cnt < 2 * k + 20) begin
      in_valid = gaps ? (cnt % 3 != 2) : 1'b1;
      take = in_valid && bus.in_ready_o;
      cyc();
      cnt++;
      if (take) sent++;
    end
    in_valid = 1'b0;
    chk("beats accepted", sent, k);
  endtask

  task automatic fill_exp(input int k);
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 4; n++) begin
        exp_c[m][n] = 64'(k) * 64'(a[m]) * 64'(b[n]);
      end
    end
  endtask

  task automatic drain(input int stall_row, input bit chk16);
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("row%0d c_valid", r), bus.c_valid_o, 1);
      chk($sformatf("row%0d c_row", r), bus.c_row_o, r);
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("c[%0d][%0d]", r, n), bus.c_o[n], exp_c[r][n]);
        if (chk16) chk($sformatf("c16[%0d][%0d]", r, n), bus16.c_o[n], exp_16[r][n]);
      end
      if (r == stall_row) begin
        c_ready  = 1'b0;
        start    = 1'b1;
        k_len    = 16'd7;
        in_valid = 1'b1;
        repeat (5) begin
          cyc();
          chk("stall c_valid", bus.c_valid_o, 1);
          chk("stall c_row", bus.c_row_o, r);
          chk("stall busy", bus.busy_o, 1);
          for (int n = 0; n < 4; n++) begin
            chk($sformatf("stall c[%0d][%0d]", r, n), bus.c_o[n], exp_c[r][n]);
          end
        end
        start    = 1'b0;
        in_valid = 1'b0;
      end
      c_ready = 1'b1;
      cyc();
      c_ready = 1'b0;
    end
    chk("done pulse", bus.done_o, 1);
    chk("done busy", bus.busy_o, 0);
    chk("done c_valid", bus.c_valid_o, 0);
    chk("done c_o[0]", bus.c_o[0], 0);
    cyc();
    chk("done cleared", bus.done_o, 0);
    chk("idle in_ready", bus.in_ready_o, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    c_ready  = 1'b0;
    a        = '{0, 0, 0, 0};
    b        = '{0, 0, 0, 0};

    repeat (2) cyc();
    check_idle_zero("reset");
    rst = 1'b0;
    cyc();

    // reset in the middle of random traffic
    start_tile(5);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = 8'($urandom);
        b[j] = 8'($urandom);
      end
      in_valid = 1'b1;
      cyc();
    end
    rst   = 1'b1;
    start = 1'b1;
    cyc();
    check_idle_zero("midrst1");
    cyc();
    check_idle_zero("midrst2");
    rst   = 1'b0;
    start = 1'b0;
    cyc();
    check_idle_zero("post rst idle");
    in_valid = 1'b0;

    // basic tile, hand-computed table 3*a[m]*b[n]
    a = '{1, -2, 3, 4};
    b = '{5, 6, -7, 8};
    exp_c = '{'{15, 18, -21, 24}, '{-30, -36, 42, -48},
              '{45, 54, -63, 72}, '{60, 72, -84, 96}};
    start_tile(3);
    feed(3, 1'b0);
    drain(-1, 1'b0);

    // same tile with input bubbles and a 5-cycle stall on row 2
    start_tile(3);
    feed(3, 1'b1);
    drain(2, 1'b0);

    // zero K drains four rows of zeros
    fill_exp(0);
    start_tile(0);
    drain(-1, 1'b0);

    // wrap: 3*(-128*-128)=49152; 16-bit instance wraps to -16384
    a = '{-128, -128, -128, -128};
    b = '{-128, -128, -128, -128};
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 4; n++) begin
        exp_c[m][n]  = 49152;
        exp_16[m][n] = -16384;
      end
    end
    start_tile(3);
    feed(3, 1'b0);
    drain(-1, 1'b1);

    // abort after 2 of 4 beats, then restart with k_len=1
    a = '{1, -2, 3, 4};
    b = '{5, 6, -7, 8};
    start_tile(4);
    feed(2, 1'b0);
    rst = 1'b1;
    cyc();
    check_idle_zero("abort");
    rst = 1'b0;
    a = '{2, 2, 2, 2};
    b = '{3, 3, 3, 3};
    for (int m = 0; m < 4; m++) begin
      for (int n = 0; n < 4; n++) exp_c[m][n] = 6;
    end
    start_tile(1);
    feed(1, 1'b0);
    drain(-1, 1'b0);

    // maximum k_len without counter wrap
    a = '{1, -1, 2, 0};
    b = '{1, 1, -1, 3};
    fill_exp(65535);
    start_tile(65535);
    feed(65535, 1'b0);
    drain(-1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
